// File: rtl/exc_word_gen.sv
// Dual-lane exception collector: carries IF/ID/EX/MEM causes down a shadow
// pipeline and priority-encodes them at MEM into CP0 control words.
module exc_word_gen #(
    parameter int PC_W  = 32,
    parameter int EXC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            cp0_intexp_1,
    input  logic            cp0_intexp_2,
    input  logic            cp0_cln_1,
    input  logic            cp0_cln_2,
    input  logic            if_valid_1,
    input  logic            if_valid_2,
    input  logic [PC_W-1:0] if_pc_1,
    input  logic [PC_W-1:0] if_pc_2,
    input  logic            if_adel_1,
    input  logic            if_adel_2,
    input  logic            id_ri_1,
    input  logic            id_ri_2,
    input  logic            id_break_1,
    input  logic            id_break_2,
    input  logic            id_sys_1,
    input  logic            id_sys_2,
    input  logic            id_eret_1,
    input  logic            id_eret_2,
    input  logic            id_branch_1,
    input  logic            id_branch_2,
    input  logic            ex_ov_1,
    input  logic            ex_ov_2,
    input  logic            mem_adel_1,
    input  logic            mem_adel_2,
    input  logic            mem_ades_1,
    input  logic            mem_ades_2,
    input  logic [PC_W-1:0] mem_addr_1,
    input  logic [PC_W-1:0] mem_addr_2,
    output logic [15:0]     cp0_int_contr_word_1,
    output logic [15:0]     cp0_int_contr_word_2,
    output logic [PC_W-1:0] PC_1,
    output logic [PC_W-1:0] PC_2,
    output logic [PC_W-1:0] orginalVritualAddrT_1,
    output logic [PC_W-1:0] orginalVritualAddrT_2,
    output logic            branch_1
);

    typedef struct packed {
        logic             valid;
        logic [PC_W-1:0]  pc;
        logic [EXC_W-1:0] cause;
        logic             dslot;
        logic             branch;
    } stage_t;

    // Fault order first, eret last.
    localparam int PRIO [8] = '{0, 1, 4, 3, 2, 5, 7, 6};

    logic [1:0]      if_valid, if_adel, id_ri, id_break, id_sys, id_eret;
    logic [1:0]      id_branch, ex_ov, mem_adel, mem_ades;
    logic [PC_W-1:0] if_pc [2];
    logic [PC_W-1:0] mem_addr [2];

    assign if_valid  = {if_valid_2, if_valid_1};
    assign if_adel   = {if_adel_2, if_adel_1};
    assign id_ri     = {id_ri_2, id_ri_1};
    assign id_break  = {id_break_2, id_break_1};
    assign id_sys    = {id_sys_2, id_sys_1};
    assign id_eret   = {id_eret_2, id_eret_1};
    assign id_branch = {id_branch_2, id_branch_1};
    assign ex_ov     = {ex_ov_2, ex_ov_1};
    assign mem_adel  = {mem_adel_2, mem_adel_1};
    assign mem_ades  = {mem_ades_2, mem_ades_1};
    assign if_pc[0]    = if_pc_1;
    assign if_pc[1]    = if_pc_2;
    assign mem_addr[0] = mem_addr_1;
    assign mem_addr[1] = mem_addr_2;

    logic   flush_all;
    stage_t id_q [2];
    stage_t id_d [2];
    stage_t ex_q [2];
    stage_t ex_d [2];
    stage_t mem_q [2];
    stage_t mem_d [2];
    logic   next_ds_q, next_ds_d;

    assign flush_all = flush | cp0_intexp_1 | cp0_intexp_2 | cp0_cln_1 | cp0_cln_2;

    always_comb begin
        next_ds_d = next_ds_q;
        for (int l = 0; l < 2; l++) begin
            id_d[l]  = id_q[l];
            ex_d[l]  = ex_q[l];
            mem_d[l] = mem_q[l];
        end
        if (flush_all) begin
            next_ds_d = 1'b0;
            for (int l = 0; l < 2; l++) begin
                id_d[l].valid   = 1'b0;
                id_d[l].cause   = '0;
                id_d[l].dslot   = 1'b0;
                id_d[l].branch  = 1'b0;
                ex_d[l].valid   = 1'b0;
                ex_d[l].cause   = '0;
                ex_d[l].dslot   = 1'b0;
                ex_d[l].branch  = 1'b0;
                mem_d[l].valid  = 1'b0;
                mem_d[l].cause  = '0;
                mem_d[l].dslot  = 1'b0;
                mem_d[l].branch = 1'b0;
            end
        end else if (!stall) begin
            for (int l = 0; l < 2; l++) begin
                id_d[l].valid    = if_valid[l];
                id_d[l].pc       = if_pc[l];
                id_d[l].cause    = '0;
                id_d[l].cause[0] = if_adel[l] & if_valid[l];
                id_d[l].dslot    = 1'b0;
                id_d[l].branch   = 1'b0;

                ex_d[l] = id_q[l];
                if (id_q[l].valid) begin
                    ex_d[l].cause[1] = id_q[l].cause[1] | id_ri[l];
                    ex_d[l].cause[3] = id_q[l].cause[3] | id_break[l];
                    ex_d[l].cause[4] = id_q[l].cause[4] | id_sys[l];
                    ex_d[l].cause[6] = id_q[l].cause[6] | id_eret[l];
                end
                ex_d[l].branch = id_branch[l] & id_q[l].valid;

                mem_d[l] = ex_q[l];
                mem_d[l].cause[2] = ex_q[l].cause[2] | (ex_ov[l] & ex_q[l].valid);
            end
            // Lane 2 sits in lane 1's delay slot; lane 1 inherits from the previous bundle's lane 2.
            ex_d[0].dslot = next_ds_q;
            ex_d[1].dslot = id_branch[0];
            next_ds_d     = id_branch[1] & id_q[1].valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            next_ds_q <= 1'b0;
            for (int l = 0; l < 2; l++) begin
                id_q[l]  <= '0;
                ex_q[l]  <= '0;
                mem_q[l] <= '0;
            end
        end else begin
            next_ds_q <= next_ds_d;
            for (int l = 0; l < 2; l++) begin
                id_q[l]  <= id_d[l];
                ex_q[l]  <= ex_d[l];
                mem_q[l] <= mem_d[l];
            end
        end
    end

    logic [EXC_W-1:0] cause_m [2];
    logic [EXC_W-1:0] sel [2];
    logic [15:0]      word [2];
    logic [PC_W-1:0]  bad_va [2];
    logic             found;
    logic             ds;

    always_comb begin
        found = 1'b0;
        ds    = 1'b0;
        for (int l = 0; l < 2; l++) begin
            cause_m[l] = mem_q[l].cause;
            if (mem_q[l].valid) begin
                cause_m[l][5] = mem_q[l].cause[5] | mem_adel[l];
                cause_m[l][7] = mem_q[l].cause[7] | mem_ades[l];
            end else begin
                cause_m[l] = '0;
            end
            sel[l] = '0;
            found  = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (!found && cause_m[l][PRIO[k]]) begin
                    sel[l][PRIO[k]] = 1'b1;
                    found = 1'b1;
                end
            end
            ds      = mem_q[l].dslot & ~sel[l][6];
            word[l] = '0;
            if (found) begin
                word[l][15]  = 1'b1;
                word[l][9]   = ds;
                word[l][8]   = ds;
                word[l][7:0] = sel[l][7:0];
            end
            if (sel[l][5] | sel[l][7])
                bad_va[l] = mem_addr[l];
            else if (sel[l][0])
                bad_va[l] = mem_q[l].pc;
            else
                bad_va[l] = '0;
        end
        // The younger lane is killed whenever the older one excepts.
        if (word[0][15]) begin
            word[1]   = '0;
            bad_va[1] = '0;
        end
    end

    assign cp0_int_contr_word_1  = word[0];
    assign cp0_int_contr_word_2  = word[1];
    assign orginalVritualAddrT_1 = bad_va[0];
    assign orginalVritualAddrT_2 = bad_va[1];
    assign PC_1     = mem_q[0].pc;
    assign PC_2     = mem_q[1].pc;
    assign branch_1 = mem_q[0].valid & mem_q[0].branch;

endmodule

// File: tb/tb_exc_word_gen.sv
// Randomized and directed check of exc_word_gen against an instruction-level
// reference model of the shadow pipeline.
module tb_exc_word_gen;
    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [1:0]  cp0_intexp, cp0_cln;
    logic [1:0]  if_valid, if_adel, id_ri, id_break, id_sys, id_eret, id_branch;
    logic [1:0]  ex_ov, mem_adel, mem_ades;
    logic [31:0] if_pc [2];
    logic [31:0] mem_addr [2];
    logic [15:0] w1, w2;
    logic [31:0] pc1, pc2, va1, va2;
    logic        br1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    exc_word_gen dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .cp0_intexp_1(cp0_intexp[0]), .cp0_intexp_2(cp0_intexp[1]),
        .cp0_cln_1(cp0_cln[0]), .cp0_cln_2(cp0_cln[1]),
        .if_valid_1(if_valid[0]), .if_valid_2(if_valid[1]),
        .if_pc_1(if_pc[0]), .if_pc_2(if_pc[1]),
        .if_adel_1(if_adel[0]), .if_adel_2(if_adel[1]),
        .id_ri_1(id_ri[0]), .id_ri_2(id_ri[1]),
        .id_break_1(id_break[0]), .id_break_2(id_break[1]),
        .id_sys_1(id_sys[0]), .id_sys_2(id_sys[1]),
        .id_eret_1(id_eret[0]), .id_eret_2(id_eret[1]),
        .id_branch_1(id_branch[0]), .id_branch_2(id_branch[1]),
        .ex_ov_1(ex_ov[0]), .ex_ov_2(ex_ov[1]),
        .mem_adel_1(mem_adel[0]), .mem_adel_2(mem_adel[1]),
        .mem_ades_1(mem_ades[0]), .mem_ades_2(mem_ades[1]),
        .mem_addr_1(mem_addr[0]), .mem_addr_2(mem_addr[1]),
        .cp0_int_contr_word_1(w1), .cp0_int_contr_word_2(w2),
        .PC_1(pc1), .PC_2(pc2),
        .orginalVritualAddrT_1(va1), .orginalVritualAddrT_2(va2),
        .branch_1(br1)
    );

    // One in-flight instruction; stage 0 = ID, 1 = EX, 2 = MEM.
    typedef struct {
        bit        v;
        bit [31:0] pc;
        bit [7:0]  c;
        bit        ds;
        bit        br;
    } instr_t;

    instr_t pipe [2][3];
    bit     carry_ds;

    // Rank of each cause bit; eret (bit 6) ranks after every fault.
    int rank_of [8] = '{0, 1, 4, 3, 2, 5, 7, 6};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr();
        stall = 0; flush = 0; cp0_intexp = 0; cp0_cln = 0;
        if_valid = 0; if_adel = 0; id_ri = 0; id_break = 0; id_sys = 0;
        id_eret = 0; id_branch = 0; ex_ov = 0; mem_adel = 0; mem_ades = 0;
        for (int l = 0; l < 2; l++) begin
            if_pc[l] = 0; mem_addr[l] = 0;
        end
    endtask

    task automatic model_out(input int l, output logic [15:0] w, output logic [31:0] va);
        bit [7:0] c;
        int best;
        w = 0; va = 0; best = -1;
        if (!pipe[l][2].v) return;
        c = pipe[l][2].c;
        c[5] = c[5] | mem_adel[l];
        c[7] = c[7] | mem_ades[l];
        for (int b = 0; b < 8; b++)
            if (c[b] && (best < 0 || rank_of[b] < rank_of[best])) best = b;
        if (best < 0) return;
        w = 16'h8000 | (16'h1 << best);
        if (pipe[l][2].ds && best != 6) w = w | 16'h0300;
        if (best == 5 || best == 7) va = mem_addr[l];
        else if (best == 0) va = pipe[l][2].pc;
    endtask

    task automatic compare_all();
        logic [15:0] e1, e2;
        logic [31:0] a1, a2;
        model_out(0, e1, a1);
        model_out(1, e2, a2);
        if (e1[15]) begin e2 = 0; a2 = 0; end
        chk("word_1", {16'h0, w1}, {16'h0, e1});
        chk("word_2", {16'h0, w2}, {16'h0, e2});
        chk("badva_1", va1, a1);
        chk("badva_2", va2, a2);
        chk("branch_1", {31'h0, br1}, {31'h0, pipe[0][2].v & pipe[0][2].br});
        if (pipe[0][2].v) chk("pc_1", pc1, pipe[0][2].pc);
        if (pipe[1][2].v) chk("pc_2", pc2, pipe[1][2].pc);
    endtask

    // Compare current cycle, then advance the model alongside the DUT edge.
    task automatic tick();
        instr_t nx [2][3];
        bit     nds;
        bit     any_flush;
        #1;
        compare_all();
        nx = pipe;
        nds = carry_ds;
        any_flush = flush | (|cp0_intexp) | (|cp0_cln);
        if (!reset) begin
            for (int l = 0; l < 2; l++)
                for (int s = 0; s < 3; s++) nx[l][s] = '{0, 0, 0, 0, 0};
            nds = 0;
        end else if (any_flush) begin
            for (int l = 0; l < 2; l++)
                for (int s = 0; s < 3; s++) begin
                    nx[l][s].v = 0; nx[l][s].c = 0; nx[l][s].ds = 0; nx[l][s].br = 0;
                end
            nds = 0;
        end else if (!stall) begin
            for (int l = 0; l < 2; l++) begin
                nx[l][2] = pipe[l][1];
                if (pipe[l][1].v) nx[l][2].c[2] = nx[l][2].c[2] | ex_ov[l];
                nx[l][1] = pipe[l][0];
                if (pipe[l][0].v)
                    nx[l][1].c = pipe[l][0].c | {id_eret[l], 1'b0, id_sys[l], id_break[l], 1'b0, id_ri[l], 1'b0};
                nx[l][1].br = pipe[l][0].v & id_branch[l];
                nx[l][0] = '{if_valid[l], if_pc[l], {7'b0, if_valid[l] & if_adel[l]}, 0, 0};
            end
            nx[0][1].ds = carry_ds;
            nx[1][1].ds = id_branch[0];
            nds = id_branch[1] & pipe[1][0].v;
        end
        @(posedge clk);
        pipe = nx;
        carry_ds = nds;
        @(negedge clk);
    endtask

    task automatic drain();
        clr(); flush = 1; tick(); clr();
    endtask

    initial begin
        clr();
        reset = 0;
        for (int l = 0; l < 2; l++)
            for (int s = 0; s < 3; s++) pipe[l][s] = '{0, 0, 0, 0, 0};
        carry_ds = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1;
        #1;
        chk("rst_word_1", {16'h0, w1}, 32'h0);
        chk("rst_word_2", {16'h0, w2}, 32'h0);
        chk("rst_pc_1", pc1, 32'h0);
        chk("rst_branch_1", {31'h0, br1}, 32'h0);

        // Lane-1 fetch AdEL, three edges to MEM.
        if_valid[0] = 1; if_pc[0] = 32'hBFC0_0100; if_adel[0] = 1;
        tick(); clr(); tick(); #1;
        chk("ifadel_early", {16'h0, w1}, 32'h0);
        tick(); #1;
        chk("ifadel_word_1", {16'h0, w1}, 32'h8001);
        chk("ifadel_va_1", va1, 32'hBFC0_0100);
        chk("ifadel_word_2", {16'h0, w2}, 32'h0);
        drain();

        // Lane-2 syscall in lane-1 branch's delay slot.
        if_valid = 2'b11; if_pc[0] = 32'h8000_0010; if_pc[1] = 32'h8000_0014;
        tick(); clr(); id_branch[0] = 1; id_sys[1] = 1;
        tick(); clr(); tick(); #1;
        chk("sys_word_2", {16'h0, w2}, 32'h8310);
        chk("sys_word_1", {16'h0, w1}, 32'h0);
        chk("sys_branch_1", {31'h0, br1}, 32'h1);
        chk("sys_pc_2", pc2, 32'h8000_0014);
        drain();

        // Lane-2 branch, 2 stall cycles, next bundle's lane-1 ov.
        if_valid = 2'b11; if_pc[0] = 32'h100; if_pc[1] = 32'h104;
        tick();
        if_pc[0] = 32'h108; if_pc[1] = 32'h10C; id_branch[1] = 1; stall = 1;
        tick(); tick(); stall = 0;
        tick(); id_branch[1] = 0; if_valid = 0;
        tick(); ex_ov[0] = 1;
        tick(); ex_ov[0] = 0; #1;
        chk("ov_dslot_word_1", {16'h0, w1}, 32'h8304);
        chk("ov_dslot_pc_1", pc1, 32'h108);
        drain();

        // RI beats ov; lane-2 AdES killed by lane 1.
        if_valid = 2'b11; if_pc[0] = 32'h200; if_pc[1] = 32'h204;
        tick(); clr(); id_ri[0] = 1;
        tick(); clr(); ex_ov[0] = 1;
        tick(); clr(); mem_ades[1] = 1; mem_addr[1] = 32'h3; #1;
        chk("ri_word_1", {16'h0, w1}, 32'h8002);
        chk("ri_word_2", {16'h0, w2}, 32'h0);
        tick();
        drain();

        // Load AdEL held under stall, then cleared by CP0.
        if_valid[0] = 1; if_pc[0] = 32'h300;
        tick(); clr(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            stall = 1; mem_adel[0] = 1; mem_addr[0] = 32'h1001; #1;
            chk("adel_hold_word_1", {16'h0, w1}, 32'h8020);
            chk("adel_hold_va_1", va1, 32'h1001);
            tick();
        end
        cp0_intexp[0] = 1; tick(); clr(); #1;
        chk("adel_clear_word_1", {16'h0, w1}, 32'h0);
        chk("adel_clear_word_2", {16'h0, w2}, 32'h0);

        // Eret in EX dropped by reset.
        if_valid[0] = 1; if_pc[0] = 32'h400;
        tick(); clr(); id_eret[0] = 1;
        tick(); clr(); reset = 0;
        tick(); reset = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("eret_reset_word_1", {16'h0, w1}, 32'h0);
            chk("eret_reset_pc_1", pc1, 32'h0);
            tick();
        end

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            clr();
            reset      = ($urandom_range(0, 99) != 0);
            stall      = ($urandom_range(0, 99) < 20);
            flush      = ($urandom_range(0, 99) < 3);
            cp0_intexp = ($urandom_range(0, 99) < 2) ? 2'($urandom) : 2'b00;
            cp0_cln    = ($urandom_range(0, 99) < 2) ? 2'($urandom) : 2'b00;
            for (int l = 0; l < 2; l++) begin
                if_valid[l]  = ($urandom_range(0, 99) < 80);
                if_pc[l]     = $urandom;
                mem_addr[l]  = $urandom;
                if_adel[l]   = ($urandom_range(0, 99) < 6);
                id_ri[l]     = ($urandom_range(0, 99) < 6);
                id_break[l]  = ($urandom_range(0, 99) < 6);
                id_sys[l]    = ($urandom_range(0, 99) < 6);
                id_eret[l]   = ($urandom_range(0, 99) < 6);
                id_branch[l] = ($urandom_range(0, 99) < 25);
                ex_ov[l]     = ($urandom_range(0, 99) < 6);
                mem_adel[l]  = ($urandom_range(0, 99) < 6);
                mem_ades[l]  = ($urandom_range(0, 99) < 6);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
